// File: rtl/seq_multiplier_32.sv
// -----------------------------------------------------------------------------
// seq_multiplier_32
//
// Unsigned 32x32 -> 64-bit shift-and-add multiplier. One partial-product step
// is taken per clock through a single 32-bit ripple adder
// (thirty_two_bit_full_adder), so a full product takes 32 iterations.
//
// Ports
//   clk      in   1   system clock, all state updates on the rising edge
//   rst      in   1   asynchronous, active-high reset
//   start    in   1   request, honoured only in IDLE or DONE
//   a        in  32   multiplicand, captured on an accepted start
//   b        in  32   multiplier, captured on an accepted start
//   busy     out  1   high while iterating
//   done     out  1   one-cycle pulse, product valid
//   product  out 64   result register, holds until the next result
//
// Also contains thirty_two_bit_full_adder, the ripple-carry adder that is the
// multiplier's only arithmetic resource.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// thirty_two_bit_full_adder
//
// Purely combinational 32-bit ripple-carry adder.
//
// Ports
//   a          in  32  addend
//   b          in  32  addend
//   carry_in   in   1  carry into bit 0
//   sum        out 32  a + b + carry_in, low 32 bits
//   carry_out  out  1  carry out of bit 31
// -----------------------------------------------------------------------------
module thirty_two_bit_full_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);

    logic [31:0] sum_s;
    logic        carry_out_s;

    // Ripple the carry from bit 0 upward, one full-adder cell per bit.
    always_comb begin
        logic c_s;
        sum_s = 32'd0;
        c_s   = carry_in;
        for (int i = 0; i < 32; i++) begin
            sum_s[i] = a[i] ^ b[i] ^ c_s;
            c_s      = (a[i] & b[i]) | (c_s & (a[i] ^ b[i]));
        end
        carry_out_s = c_s;
    end

    assign sum       = sum_s;
    assign carry_out = carry_out_s;

endmodule

module seq_multiplier_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    state_t               state_r;
    state_t               state_next_s;

    logic [WIDTH-1:0]     m_r;
    logic [WIDTH-1:0]     p_hi_r;
    logic [WIDTH-1:0]     p_lo_r;
    logic [CNT_W-1:0]     count_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 busy_next_s;
    logic                 done_next_s;

    logic                 accept_s;
    logic                 step_s;
    logic                 last_s;

    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 carry_out_s;
    logic [WIDTH-1:0]     p_hi_next_s;
    logic [WIDTH-1:0]     p_lo_next_s;

    // Partial-product adder: P_hi + (multiplier LSB ? M : 0).
    thirty_two_bit_full_adder u_adder (
        .a         (p_hi_r),
        .b         (addend_s),
        .carry_in  (1'b0),
        .sum       (sum_s),
        .carry_out (carry_out_s)
    );

    // Select the addend and form the shifted accumulator for this step.
    always_comb begin
        if (p_lo_r[0]) begin
            addend_s = m_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        // {carry, sum, P_lo} >> 1: the adder carry lands in bit 63, so no
        // overflow is ever dropped, and the sum LSB shifts into P_lo.
        p_hi_next_s = {carry_out_s, sum_s[WIDTH-1:1]};
        p_lo_next_s = {sum_s[0], p_lo_r[WIDTH-1:1]};
    end

    // Decode when a start is accepted, when an iteration runs, and the final one.
    always_comb begin
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
        step_s = (state_r == ST_CALC);
        last_s = step_s && (count_r == LAST_COUNT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; DONE accepts start directly for back-to-back operation.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (count_r == LAST_COUNT) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so busy/done can be registered.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
            ST_CALC: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b0;
            end
            ST_DONE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
        end
    end

    // Operand capture and one shift-and-add iteration per clock while calculating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r     <= {WIDTH{1'b0}};
            p_hi_r  <= {WIDTH{1'b0}};
            p_lo_r  <= {WIDTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            m_r     <= a;
            p_hi_r  <= {WIDTH{1'b0}};
            p_lo_r  <= b;
            count_r <= {CNT_W{1'b0}};
        end else if (step_s) begin
            p_hi_r  <= p_hi_next_s;
            p_lo_r  <= p_lo_next_s;
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            m_r     <= m_r;
            p_hi_r  <= p_hi_r;
            p_lo_r  <= p_lo_r;
            count_r <= count_r;
        end
    end

    // Result register: loaded only on the final iteration, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_r <= {(2*WIDTH){1'b0}};
        end else if (last_s) begin
            product_r <= {p_hi_next_s, p_lo_next_s};
        end else begin
            product_r <= product_r;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_seq_multiplier_32.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier_32
//
// Directed bench for seq_multiplier_32. A transaction-level model (operands
// multiplied with '*', a count of remaining busy cycles) predicts busy, done
// and product every cycle; literal products and latencies pin the model.
// -----------------------------------------------------------------------------
module tb_seq_multiplier_32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int errors;
    int checks;
    bit cmp_en;

    // Model state
    int          m_left;
    logic        m_done;
    logic [63:0] m_prod;
    logic [63:0] m_pend;

    seq_multiplier_32 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_in),
        .b       (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Transaction model: an accepted start yields 32 busy cycles, then a one
    // cycle done with product = a*b. A start is honoured whenever not busy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= 64'd0;
            m_pend <= 64'd0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_prod <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left <= 32;
                m_pend <= {32'd0, a_in} * {32'd0, b_in};
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check64("cyc_busy", {63'd0, busy}, {63'd0, (m_left != 0)});
            check64("cyc_done", {63'd0, done}, {63'd0, m_done});
            check64("cyc_product", product, m_prod);
        end
    end

    // Issue one operation and wait (bounded) for done. Optionally pulse an
    // ignored start with other operands at cycle inj_cyc.
    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp, input int inj_cyc,
                          input logic [31:0] ia, input logic [31:0] ib);
        int cyc;
        int busy_cnt;
        bit seen;
        cyc = 0;
        busy_cnt = 0;
        seen = 1'b0;
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            if (cyc == inj_cyc) begin
                a_in  = ia;
                b_in  = ib;
                start = 1'b1;
            end else begin
                a_in  = 32'hDEAD_BEEF;
                b_in  = 32'hCAFE_F00D;
            end
        end
        check_int({name, "_latency"}, cyc, 33);
        check_int({name, "_busy_cycles"}, busy_cnt, 32);
        check64({name, "_product"}, product, exp);
    endtask

    initial begin
        int cyc;
        bit seen;
        errors = 0;
        checks = 0;
        cmp_en = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (3) @(negedge clk);
        check64("reset_busy", {63'd0, busy}, 64'd0);
        check64("reset_done", {63'd0, done}, 64'd0);
        check64("reset_product", product, 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        run_op("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F, -1, 32'd0, 32'd0);
        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1, 32'd0, 32'd0);
        run_op("zero", 32'd0, 32'h1234_5678, 64'd0, -1, 32'd0, 32'd0);
        run_op("ident", 32'h8000_0001, 32'd1, 64'h0000_0000_8000_0001, -1, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        run_op("ignored", 32'h10, 32'h10, 64'h100, 10, 32'd7, 32'd7);
        @(negedge clk);

        // Back-to-back: start held high into and through the DONE cycle.
        a_in  = 32'h10;
        b_in  = 32'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        a_in  = 32'h0001_0000;
        b_in  = 32'h0001_0000;
        start = 1'b1;
        @(negedge clk);
        check64("b2b_first_done", {63'd0, done}, 64'd1);
        check64("b2b_first_product", product, 64'h110);
        @(negedge clk);
        start = 1'b0;
        check64("b2b_no_bubble", {63'd0, busy}, 64'd1);
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        check_int("b2b_latency", cyc, 33);
        check64("b2b_second_product", product, 64'h0000_0001_0000_0000);
        repeat (3) @(negedge clk);

        // Reset mid-operation.
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check64("midop_busy_before", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check64("midop_rst_busy", {63'd0, busy}, 64'd0);
        check64("midop_rst_done", {63'd0, done}, 64'd0);
        check64("midop_rst_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 32'd6, 32'd7, 64'd42, -1, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check64("idle_hold_product", product, 64'd42);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
